// File: rtl/lte_ul_agc_pkg.sv
// Shared constants and helpers for the LTE uplink time-domain AGC.
//   - default channel count and data/gain widths
//   - fixed input-to-output latency
//   - rsh_amt : total right shift that removes the gain fraction and the
//               DW->OW width reduction
//   - sat_val : clamp a signed value to an ow-bit two's complement range
package lte_ul_agc_pkg;

  localparam int NCH_DEF = 8;
  localparam int DW_DEF  = 16;
  localparam int OW_DEF  = 15;
  localparam int GW_DEF  = 17;
  localparam int LAT     = 4;

  // Unity gain is 2^(GW-2). The output also drops DW-OW LSBs.
  function automatic int rsh_amt(input int gw, input int dw, input int ow);
    return (gw - 2) + (dw - ow);
  endfunction

  function automatic logic signed [63:0] sat_val(input logic signed [63:0] v,
                                                 input int ow);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (ow - 1));
    if (v > hi)
      return hi;
    else if (v < lo)
      return lo;
    else
      return v;
  endfunction

endpackage

// File: rtl/lte_agc_mul_rnd_sat.sv
// One I or Q rail of the AGC: multiply, shift, round half-up, saturate.
// Three register stages (product, rounded value, saturated output).
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   valid       : sample valid, aligned with x/g
//   bypass      : 1 = output truncated x instead of the gained value
//   shift       : extra left shift 0..3 applied to the product
//   x           : signed input sample (DW)
//   g           : unsigned linear gain (GW), unity = 2^(GW-2)
//   y           : registered result (OW), 0 when not valid
//   clip        : combinational; high when the value being registered into
//                 y this cycle was saturated (valid, non-bypass only)
module lte_agc_mul_rnd_sat
  import lte_ul_agc_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int OW = OW_DEF,
  parameter int GW = GW_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid,
  input  logic                 bypass,
  input  logic [1:0]           shift,
  input  logic signed [DW-1:0] x,
  input  logic [GW-1:0]        g,
  output logic [OW-1:0]        y,
  output logic                 clip
);

  localparam int PW = DW + GW + 1;   // product width (gain made signed)
  localparam int QW = PW + 3;        // room for the 0..3 extra shift
  localparam int K  = rsh_amt(GW, DW, OW);
  localparam logic signed [QW-1:0] HALF = QW'(1) << (K - 1);

  // stage 2: product
  logic signed [PW-1:0] p2;
  logic [1:0]           sh2;
  logic                 v2;
  logic                 byp2;
  logic [OW-1:0]        tr2;

  // stage 3: shifted and rounded
  logic signed [QW-1:0] q3_comb;
  logic signed [QW-1:0] r3_comb;
  logic signed [QW-1:0] r3;
  logic                 v3;
  logic                 byp3;
  logic [OW-1:0]        tr3;

  // stage 4: saturated
  logic signed [63:0]   r3_ext;
  logic signed [63:0]   sat4;
  logic                 ovf4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p2   <= '0;
      sh2  <= '0;
      v2   <= 1'b0;
      byp2 <= 1'b0;
      tr2  <= '0;
    end else begin
      p2   <= PW'(x) * PW'($signed({1'b0, g}));
      sh2  <= shift;
      v2   <= valid;
      byp2 <= bypass;
      tr2  <= x[DW-1 -: OW];
    end
  end

  always_comb begin
    q3_comb = QW'(p2) <<< sh2;
    r3_comb = (q3_comb + HALF) >>> K;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r3   <= '0;
      v3   <= 1'b0;
      byp3 <= 1'b0;
      tr3  <= '0;
    end else begin
      r3   <= r3_comb;
      v3   <= v2;
      byp3 <= byp2;
      tr3  <= tr2;
    end
  end

  always_comb begin
    r3_ext = 64'($signed(r3));
    sat4   = sat_val(r3_ext, OW);
    ovf4   = (sat4 != r3_ext);
    clip   = v3 & ~byp3 & ovf4;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      y <= '0;
    else if (!v3)
      y <= '0;
    else if (byp3)
      y <= tr3;
    else
      y <= sat4[OW-1:0];
  end

endmodule

// File: rtl/lte_ul_tdl_agc_mc.sv
// Multi-channel uplink time-domain AGC for TDM-interleaved I/Q samples.
// Per-antenna linear gain, 0/6/12/18 dB shift, round half-up, saturation,
// sticky per-channel clip flags and a matched-latency bypass.
// Ports:
//   clk_245, asy_rst_n        : clock, asynchronous active-low reset
//   i_data {I,Q}, i_data_valid: input samples and strobe
//   i_fram_hd                 : frame header (channel-0 sample), valid-qualified
//   i_ant_sel                 : sideband, delayed with data
//   i_gain                    : NCH packed gains, ch0 in LSBs
//   i_shift_sel, i_bypass     : per-sample shift and bypass controls
//   i_sat_clr                 : clears o_sat_flag
//   o_data .. o_ch_idx        : results and sidebands, LAT cycles later
//   o_sat_flag                : sticky clip flag per channel
module lte_ul_tdl_agc_mc
  import lte_ul_agc_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int DW  = DW_DEF,
  parameter int OW  = OW_DEF,
  parameter int GW  = GW_DEF,
  parameter int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic               clk_245,
  input  logic               asy_rst_n,
  input  logic [2*DW-1:0]    i_data,
  input  logic               i_data_valid,
  input  logic               i_fram_hd,
  input  logic               i_ant_sel,
  input  logic [NCH*GW-1:0]  i_gain,
  input  logic [1:0]         i_shift_sel,
  input  logic               i_bypass,
  input  logic               i_sat_clr,
  output logic [2*OW-1:0]    o_data,
  output logic               o_data_valid,
  output logic               o_fram_hd,
  output logic               o_ant_sel,
  output logic [CW-1:0]      o_ch_idx,
  output logic [NCH-1:0]     o_sat_flag
);

  logic           hd_valid;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  cnt_next;
  logic [CW-1:0]  cur_ch;
  logic [GW-1:0]  shadow [NCH];
  logic [GW-1:0]  g_sel;

  // stage 1 registers
  logic signed [DW-1:0] x_i1;
  logic signed [DW-1:0] x_q1;
  logic [GW-1:0]        g1;
  logic [1:0]           sh1;
  logic                 byp1;

  // sideband delay lines, index 0 = stage 1
  logic [LAT-1:0] valid_dl;
  logic [LAT-1:0] hd_dl;
  logic [LAT-1:0] ant_dl;
  logic [CW-1:0]  ch_dl [LAT];

  logic [OW-1:0]  y_i;
  logic [OW-1:0]  y_q;
  logic           clip_i;
  logic           clip_q;
  logic [NCH-1:0] set_vec;

  assign hd_valid = i_data_valid & i_fram_hd;

  always_comb begin
    cur_ch   = hd_valid ? '0 : cnt;
    cnt_next = cnt;
    if (hd_valid)
      cnt_next = (NCH > 1) ? CW'(1) : '0;
    else if (i_data_valid)
      cnt_next = (cnt == CW'(NCH - 1)) ? '0 : cnt + 1'b1;
  end

  // The header sample is ch0 and must already see the newly loaded gain,
  // so it takes the gain straight from the input rather than the shadow.
  assign g_sel = hd_valid ? i_gain[GW-1:0] : shadow[cnt];

  always_ff @(posedge clk_245 or negedge asy_rst_n) begin
    if (!asy_rst_n)
      cnt <= '0;
    else
      cnt <= cnt_next;
  end

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_shadow
      always_ff @(posedge clk_245 or negedge asy_rst_n) begin
        if (!asy_rst_n)
          shadow[gi] <= '0;
        else if (hd_valid)
          shadow[gi] <= i_gain[gi*GW +: GW];
      end
    end
  endgenerate

  always_ff @(posedge clk_245 or negedge asy_rst_n) begin
    if (!asy_rst_n) begin
      x_i1 <= '0;
      x_q1 <= '0;
      g1   <= '0;
      sh1  <= '0;
      byp1 <= 1'b0;
    end else begin
      x_i1 <= i_data[2*DW-1:DW];
      x_q1 <= i_data[DW-1:0];
      g1   <= g_sel;
      sh1  <= i_shift_sel;
      byp1 <= i_bypass;
    end
  end

  always_ff @(posedge clk_245 or negedge asy_rst_n) begin
    if (!asy_rst_n) begin
      valid_dl <= '0;
      hd_dl    <= '0;
      ant_dl   <= '0;
      ch_dl[0] <= '0;
    end else begin
      valid_dl <= {valid_dl[LAT-2:0], i_data_valid};
      hd_dl    <= {hd_dl[LAT-2:0], i_fram_hd};
      ant_dl   <= {ant_dl[LAT-2:0], i_ant_sel};
      ch_dl[0] <= cur_ch;
    end
  end

  generate
    for (genvar gi = 1; gi < LAT; gi++) begin : g_ch_dl
      always_ff @(posedge clk_245 or negedge asy_rst_n) begin
        if (!asy_rst_n)
          ch_dl[gi] <= '0;
        else
          ch_dl[gi] <= ch_dl[gi-1];
      end
    end
  endgenerate

  lte_agc_mul_rnd_sat #(.DW(DW), .OW(OW), .GW(GW)) u_rail_i (
    .clk    (clk_245),
    .rst_n  (asy_rst_n),
    .valid  (valid_dl[0]),
    .bypass (byp1),
    .shift  (sh1),
    .x      (x_i1),
    .g      (g1),
    .y      (y_i),
    .clip   (clip_i)
  );

  lte_agc_mul_rnd_sat #(.DW(DW), .OW(OW), .GW(GW)) u_rail_q (
    .clk    (clk_245),
    .rst_n  (asy_rst_n),
    .valid  (valid_dl[0]),
    .bypass (byp1),
    .shift  (sh1),
    .x      (x_q1),
    .g      (g1),
    .y      (y_q),
    .clip   (clip_q)
  );

  // Clip is reported while the sample moves into the output register, so
  // the channel tag is taken from the stage just before the output.
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_set
      assign set_vec[gi] = (clip_i | clip_q) && (ch_dl[LAT-2] == CW'(gi));
    end
  endgenerate

  // A clear and a new clip on the same cycle keep the clipping channel set.
  always_ff @(posedge clk_245 or negedge asy_rst_n) begin
    if (!asy_rst_n)
      o_sat_flag <= '0;
    else
      o_sat_flag <= (i_sat_clr ? '0 : o_sat_flag) | set_vec;
  end

  assign o_data       = {y_i, y_q};
  assign o_data_valid = valid_dl[LAT-1];
  assign o_fram_hd    = hd_dl[LAT-1];
  assign o_ant_sel    = ant_dl[LAT-1];
  assign o_ch_idx     = ch_dl[LAT-1];

endmodule

// File: tb/tb_lte_ul_tdl_agc_mc.sv
module tb_lte_ul_tdl_agc_mc;

  localparam int NCH = 8;
  localparam int DW  = 16;
  localparam int OW  = 15;
  localparam int GW  = 17;
  localparam int CW  = 3;
  localparam int K   = (GW - 2) + (DW - OW);
  localparam int NE  = 2048;

  logic              clk_245 = 1'b0;
  logic              asy_rst_n;
  logic [2*DW-1:0]   i_data;
  logic              i_data_valid;
  logic              i_fram_hd;
  logic              i_ant_sel;
  logic [NCH*GW-1:0] i_gain;
  logic [1:0]        i_shift_sel;
  logic              i_bypass;
  logic              i_sat_clr;
  logic [2*OW-1:0]   o_data;
  logic              o_data_valid;
  logic              o_fram_hd;
  logic              o_ant_sel;
  logic [CW-1:0]     o_ch_idx;
  logic [NCH-1:0]    o_sat_flag;

  always #5 clk_245 = ~clk_245;

  lte_ul_tdl_agc_mc #(.NCH(NCH), .DW(DW), .OW(OW), .GW(GW), .CW(CW)) dut (
    .clk_245      (clk_245),
    .asy_rst_n    (asy_rst_n),
    .i_data       (i_data),
    .i_data_valid (i_data_valid),
    .i_fram_hd    (i_fram_hd),
    .i_ant_sel    (i_ant_sel),
    .i_gain       (i_gain),
    .i_shift_sel  (i_shift_sel),
    .i_bypass     (i_bypass),
    .i_sat_clr    (i_sat_clr),
    .o_data       (o_data),
    .o_data_valid (o_data_valid),
    .o_fram_hd    (o_fram_hd),
    .o_ant_sel    (o_ant_sel),
    .o_ch_idx     (o_ch_idx),
    .o_sat_flag   (o_sat_flag)
  );

  int n_cmp = 0;
  int n_err = 0;
  int edge_cnt = 0;

  // expectations indexed by the clock edge that captures the input
  bit            e_set  [NE];
  bit            e_v    [NE];
  bit            e_hd   [NE];
  bit            e_ant  [NE];
  bit            e_clip [NE];
  bit            e_clr  [NE];
  int            e_ch   [NE];
  logic [2*OW-1:0] e_dat [NE];

  // reference model state
  int          m_cnt = 0;
  int unsigned m_shadow [NCH];
  logic [NCH-1:0] fm = '0;

  always @(posedge clk_245) edge_cnt <= edge_cnt + 1;

  function automatic logic [2*OW-1:0] pack(input int vi, input int vq);
    return {OW'(vi), OW'(vq)};
  endfunction

  // Output value of one rail from the arithmetic definition.
  function automatic longint rail(input longint x, input longint g, input int sh,
                                  input bit byp, output bit clip);
    longint q, r, hi, lo;
    clip = 1'b0;
    if (byp) return x >>> (DW - OW);
    q  = x * g * (longint'(1) << sh);
    r  = (q + (longint'(1) << (K - 1))) >>> K;
    hi = (longint'(1) << (OW - 1)) - 1;
    lo = -(longint'(1) << (OW - 1));
    if (r > hi) begin clip = 1'b1; return hi; end
    if (r < lo) begin clip = 1'b1; return lo; end
    return r;
  endfunction

  task automatic lit(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end else
      $display("ok   %s: %0h", name, got);
  endtask

  task automatic set_gain(input int ch, input int unsigned g);
    i_gain[ch*GW +: GW] = GW'(g);
  endtask

  task automatic step(input bit v, input bit hd, input bit ant, input int xi, input int xq,
                      input int sh, input bit byp, input bit clr);
    int idx, ch;
    longint ri, rq;
    bit ci, cq;
    logic [63:0] vi, vq;
    idx = edge_cnt;
    i_data_valid = v;
    i_fram_hd    = hd;
    i_ant_sel    = ant;
    i_data       = {DW'(xi), DW'(xq)};
    i_shift_sel  = 2'(sh);
    i_bypass     = byp;
    i_sat_clr    = clr;
    ch = 0;
    e_dat[idx]  = '0;
    e_clip[idx] = 1'b0;
    if (v) begin
      if (hd) begin
        for (int c = 0; c < NCH; c++) m_shadow[c] = i_gain[c*GW +: GW];
        ch = 0;
        m_cnt = (NCH > 1) ? 1 : 0;
      end else begin
        ch = m_cnt;
        m_cnt = (m_cnt + 1) % NCH;
      end
      ri = rail(longint'(xi), longint'(m_shadow[ch]), sh, byp, ci);
      rq = rail(longint'(xq), longint'(m_shadow[ch]), sh, byp, cq);
      vi = ri;
      vq = rq;
      e_dat[idx]  = {vi[OW-1:0], vq[OW-1:0]};
      e_clip[idx] = ci | cq;
    end
    e_set[idx] = 1'b1;
    e_v[idx]   = v;
    e_hd[idx]  = hd;
    e_ant[idx] = ant;
    e_ch[idx]  = ch;
    e_clr[idx] = clr;
    @(posedge clk_245);
    #1;
  endtask

  // per-cycle comparison against the model
  always @(negedge clk_245) begin
    int m, ei;
    bit ok;
    m  = edge_cnt - 1;
    ei = m - 3;
    if (!asy_rst_n) begin
      fm = '0;
    end else if (m >= 0) begin
      if (ei >= 0 && e_set[ei]) begin
        n_cmp++;
        ok = (o_data_valid == e_v[ei]) && (o_data == e_dat[ei]) &&
             (o_fram_hd == e_hd[ei]) && (o_ant_sel == e_ant[ei]) &&
             (!e_v[ei] || (int'(o_ch_idx) == e_ch[ei]));
        if (!ok) begin
          n_err++;
          $display("FAIL out@%0d: got v=%0b d=%0h hd=%0b ant=%0b ch=%0d expected v=%0b d=%0h hd=%0b ant=%0b ch=%0d",
                   ei, o_data_valid, o_data, o_fram_hd, o_ant_sel, o_ch_idx,
                   e_v[ei], e_dat[ei], e_hd[ei], e_ant[ei], e_ch[ei]);
        end else if (e_v[ei])
          $display("ok   out@%0d ch=%0d d=%0h", ei, o_ch_idx, o_data);
      end
      if (e_set[m] && e_clr[m]) fm = '0;
      if (ei >= 0 && e_set[ei] && e_clip[ei]) fm[e_ch[ei]] = 1'b1;
      n_cmp++;
      if (o_sat_flag !== fm) begin
        n_err++;
        $display("FAIL sat_flag@%0d: got %0h expected %0h", m, o_sat_flag, fm);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int ch, n;
    asy_rst_n = 1'b0;
    i_data = '0; i_data_valid = 0; i_fram_hd = 0; i_ant_sel = 0;
    i_shift_sel = 0; i_bypass = 0; i_sat_clr = 0;
    for (int c = 0; c < NCH; c++) set_gain(c, 32768);
    repeat (3) @(posedge clk_245);
    #1;
    lit("rst_valid", 64'(o_data_valid), 64'd0);
    lit("rst_data",  64'(o_data), 64'd0);
    lit("rst_flag",  64'(o_sat_flag), 64'd0);
    lit("rst_ch",    64'(o_ch_idx), 64'd0);
    asy_rst_n = 1'b1;

    // unity gain, header on ch0
    step(1, 1, 0, 1000, -1000, 0, 0, 0);
    for (int c = 1; c < 4; c++) step(1, 0, 1, 1000, -1000, 0, 0, 0);
    lit("t1_data", 64'(o_data), 64'(pack(500, -500)));
    lit("t1_ch",   64'(o_ch_idx), 64'd0);
    lit("t1_hd",   64'(o_fram_hd), 64'd1);
    // rounding half-up on ch4
    step(1, 0, 0, 1001, -1001, 0, 0, 0);
    for (int c = 5; c < 8; c++) step(1, 0, 0, 1000, -1000, 0, 0, 0);
    lit("t2_round", 64'(o_data), 64'(pack(501, -500)));
    lit("t2_ch",    64'(o_ch_idx), 64'd4);

    // saturation on ch3
    set_gain(3, 65535);
    step(1, 1, 0, 1000, -1000, 0, 0, 0);
    for (int c = 1; c < 3; c++) step(1, 0, 0, 1000, -1000, 0, 0, 0);
    step(1, 0, 0, 32767, -32768, 3, 0, 0);
    for (int c = 4; c < 7; c++) step(1, 0, 0, 1000, -1000, 0, 0, 0);
    lit("t3_sat",  64'(o_data), 64'(pack(16383, -16384)));
    lit("t3_flag", 64'(o_sat_flag), 64'h08);
    step(1, 0, 0, 1000, -1000, 0, 0, 1);
    lit("t3_clr_noclip", 64'(o_sat_flag), 64'h00);
    step(1, 1, 0, 1000, -1000, 0, 0, 0);
    for (int c = 1; c < 3; c++) step(1, 0, 0, 1000, -1000, 0, 0, 0);
    step(1, 0, 0, 32767, -32768, 3, 0, 0);
    for (int c = 4; c < 6; c++) step(1, 0, 0, 1000, -1000, 0, 0, 0);
    step(1, 0, 0, 1000, -1000, 0, 0, 1);
    lit("t3_clr_and_clip", 64'(o_sat_flag), 64'h08);
    step(1, 0, 0, 1000, -1000, 0, 0, 1);
    lit("t3_clr", 64'(o_sat_flag), 64'h00);
    set_gain(3, 32768);

    // gain change mid-frame waits for the next header
    step(1, 1, 0, 1000, -1000, 0, 0, 0);
    step(1, 0, 0, 1000, -1000, 0, 0, 0);
    set_gain(2, 16384);
    for (int c = 2; c < 6; c++) step(1, 0, 0, 1000, -1000, 0, 0, 0);
    lit("t4_hold", 64'(o_data), 64'(pack(500, -500)));
    for (int c = 6; c < 8; c++) step(1, 0, 0, 1000, -1000, 0, 0, 0);
    step(1, 1, 0, 1000, -1000, 0, 0, 0);
    for (int c = 1; c < 6; c++) step(1, 0, 0, 1000, -1000, 0, 0, 0);
    lit("t4_new", 64'(o_data), 64'(pack(250, -250)));
    for (int c = 6; c < 8; c++) step(1, 0, 0, 1000, -1000, 0, 0, 0);
    set_gain(2, 32768);

    // valid gaps over three frames
    for (int f = 0; f < 3; f++) begin
      ch = 0;
      while (ch < NCH) begin
        if ($urandom_range(0, 99) < 60) begin
          step(1, ch == 0, 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 65535)) - 32768,
               int'($urandom_range(0, 65535)) - 32768,
               int'($urandom_range(0, 3)), 0, 0);
          ch++;
        end else
          step(0, 0, 1'($urandom_range(0, 1)), 0, 0, 0, 0, 0);
      end
    end
    repeat (4) step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);

    // bypass toggled every 5 samples
    for (n = 0; n < 16; n++) begin
      step(1, (n % NCH) == 0, 0, 32'h1235, -1000, 0, ((n / 5) % 2) == 1, 0);
      if (n == 7) lit("t6_gained", 64'(o_data), 64'(pack(2331, -500)));
      if (n == 8) lit("t6_bypass", 64'(o_data), 64'(pack(32'h091A, -500)));
    end
    repeat (4) step(0, 0, 0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lte_ul_tdl_agc_mc.md
Name: lte_ul_tdl_agc_mc

Overview:
- Parametrised multi-channel uplink time-domain AGC for the LTE UL datapath. It applies a per-antenna linear digital gain to TDM-interleaved I/Q samples, then a 0/6/12/18 dB shift, round-half-up and saturation.
- It sits between the DDC output and the UL FFT/CP-removal stage.
- Beyond the 8-antenna fixed block it adds:
  - generic channel count and widths
  - counting on valid samples only
  - gain updates applied only at frame header, so there is no mid-frame gain step
  - sticky per-channel saturation flags
  - a bypass mode with matched latency

Parameters:
NCH, 8, number of TDM-interleaved antennas per sample period (>=1)
DW, 16, input I and Q width, signed two's complement
OW, 15, output I and Q width, signed (OW<=DW)
GW, 17, linear gain width, unsigned; unity = 2^(GW-2)
CW, $clog2(NCH) (min 1), channel index width

Ports:
clk_245  in  1  datapath clock, all logic rising-edge
asy_rst_n  in  1  asynchronous active-low reset
i_data  in  2*DW  {I,Q}; I in upper half
i_data_valid  in  1  sample strobe
i_fram_hd  in  1  frame header; qualified by i_data_valid; marks channel-0 sample
i_ant_sel  in  1  sideband, delayed with data
i_gain  in  NCH*GW  per-channel gain; ch0 in LSBs; quasi-static register input
i_shift_sel  in  2  extra left shift 0..3 (0/6/12/18 dB)
i_bypass  in  1  1 = skip gain and shift, truncate only
i_sat_clr  in  1  single-cycle clear of o_sat_flag
o_data  out  2*OW  {I,Q} result
o_data_valid  out  1  delayed i_data_valid
o_fram_hd  out  1  delayed i_fram_hd
o_ant_sel  out  1  delayed i_ant_sel
o_ch_idx  out  CW  channel index of o_data
o_sat_flag  out  NCH  sticky saturation flag per channel

Behaviour:
- Reset: all pipeline registers, outputs, channel counter, gain shadow and sat flags go to 0.
- Fixed latency LAT=4 cycles from input to output for data, valid, fram_hd, ant_sel and ch_idx. The pipeline advances every cycle regardless of valid.
- o_data is forced to 0 whenever o_data_valid=0.
- Channel counter:
  - i_data_valid & i_fram_hd: sample is ch 0; counter becomes 1 (0 if NCH=1).
  - i_data_valid only: sample uses the current count; counter increments and wraps NCH-1 -> 0.
  - No valid: counter holds.
  - i_fram_hd without i_data_valid is ignored.
- Gain shadow:
  - On a valid header sample, the shadow loads all of i_gain. That header sample already uses the new gains (bypass mux feeds i_gain directly on that cycle).
  - Otherwise the shadow holds, so i_gain changes mid-frame have no effect until the next header.
  - Until the first header, the shadow is 0 and output is 0 (unless bypass).
- Pipeline stages:
  - S1: register data, channel index and selected gain g.
  - S2: signed product p = x*g, DW+GW+1 bits, I and Q in parallel.
  - S3: compute q = p << shift_sel, then arithmetic right shift by (GW-2)+(DW-OW) with round half-up (add 2^(k-1) before shifting).
  - S4: saturate to OW bits, [-2^(OW-1), 2^(OW-1)-1], and register.
- Bypass:
  - i_bypass and i_shift_sel are sampled in S1 per sample.
  - Bypass output = x[DW-1 -: OW] (truncation, no rounding, no saturation), delivered with the same LAT.
  - Toggling bypass produces no bubble or duplicate sample.
- Sat flags:
  - At S4, if valid and (I or Q) clipped, set o_sat_flag[ch].
  - i_sat_clr clears all flags next cycle.
  - A set event and a clear on the same cycle leave that channel's flag set. Other channels are cleared.
  - Bypass never sets flags.
- Reset asserted mid-stream: outputs go to 0 immediately (async). After release, no output is valid until new valid input has traversed LAT cycles, and the gains need a header to load.

Decomposition:
- Package lte_ul_agc_pkg holds:
  - default NCH/DW/OW/GW
  - LAT=4
  - the function computing the right-shift amount (GW-2)+(DW-OW)
  - a saturate function
- One sub-module, lte_agc_mul_rnd_sat (one rail: multiply, shift, round, saturate, sat flag out, 3 register stages), instantiated for I and Q.
- The top level holds the counter, shadow, bypass mux, sideband delay lines and flags.

Test Plan:
1. Reset, then a valid header with gains all 2^15, shift 0, x=I1000/Q-1000 -> 4 cycles later o_data = I500/Q-500, o_ch_idx=0, o_fram_hd=1.
2. Rounding: gain unity, I=1001, Q=-1001 -> I=501, Q=-500 (half-up).
3. Saturation:
   - ch3 gain 65535, shift 3, I=32767, Q=-32768 -> I=16383, Q=-16384; o_sat_flag=8'h08.
   - i_sat_clr pulse on the same cycle as a new ch3 clip -> flag stays 8'h08.
   - i_sat_clr with no clip -> 8'h00.
4. Gain shadow:
   - Change ch2 gain from 2^15 to 2^14 mid-frame -> ch2 output unchanged (I=500 for x=1000).
   - At the next header -> ch2 gives 250.
5. Valid gaps: random i_data_valid duty (~60%) over 3 frames of NCH=8 -> o_ch_idx sequence 0..7 repeating on valid outputs only; invalid outputs have o_data=0.
6. Bypass: toggle i_bypass every 5 samples with x=I0x1235 -> bypassed outputs I=0x091A (truncated), gained outputs correct; no sample lost; latency constant at 4.
